// File: rtl/hazard_forward_ctrl_pkg.sv
// hazard_forward_ctrl_pkg: shared tracking-entry type and select-width helper
package hazard_forward_ctrl_pkg;
    localparam int RD_MAX = 8;
    localparam int FWD_RF = 0;
    typedef struct packed {
        logic              valid;
        logic [RD_MAX-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              mfwd;
    } entry_t;
    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: decode-slot request and stall/forward response bundle
interface hazard_forward_ctrl_if #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2
);
    logic                     id_valid;
    logic [REG_W-1:0]         id_rd;
    logic                     id_regwrite;
    logic                     id_memread;
    logic                     id_memwrite;
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic [NUM_SRC-1:0]       id_src_used;
    logic                     flush;
    logic                     freeze;
    logic                     stall;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     mem_fwd;
    logic [15:0]              stall_cnt;
    modport master (
        output id_valid, id_rd, id_regwrite, id_memread, id_memwrite, id_src, id_src_used, flush, freeze,
        input  stall, fwd_sel, mem_fwd, stall_cnt
    );
    modport slave (
        input  id_valid, id_rd, id_regwrite, id_memread, id_memwrite, id_src, id_src_used, flush, freeze,
        output stall, fwd_sel, mem_fwd, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_ctrl_match.sv
// hfc_match: priority comparator of one source against the tracked writers, youngest first
module hfc_match import hazard_forward_ctrl_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int SEL_W = 2
) (
    input  logic [RD_MAX-1:0] src,
    input  logic              used,
    input  logic [DEPTH-1:0]  wr,
    input  logic [RD_MAX-1:0] rd [DEPTH],
    output logic [SEL_W-1:0]  sel,
    output logic              hit
);
    logic [DEPTH-1:0] m;
    always_comb begin
        m   = '0;
        sel = SEL_W'(FWD_RF);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            m[i] = used & wr[i] & (rd[i] == src);
            if (m[i]) sel = SEL_W'(i + 1);
        end
    end
    assign hit = m[0];
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use stall, registered EX forwarding selects and MEM-to-MEM store forward
module hazard_forward_ctrl import hazard_forward_ctrl_pkg::*; #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int MEM_FWD = 1,
    parameter int SEL_W   = sel_w(DEPTH)
) (
    input logic clk,
    input logic rst,
    hazard_forward_ctrl_if.slave bus
);
    entry_t                   ent [DEPTH+1];
    entry_t                   e_n;
    logic [DEPTH-1:0]         wr;
    logic [RD_MAX-1:0]        rd [DEPTH];
    logic [NUM_SRC-1:0]       hit;
    logic [NUM_SRC*SEL_W-1:0] sel, sel_n;
    logic                     load_e, mem_exc, take;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wr[i] = ent[i].valid & ent[i].regwrite & (|ent[i].rd);
            rd[i] = ent[i].rd;
        end
    end
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hfc_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
            .src (RD_MAX'(bus.id_src[s*REG_W +: REG_W])),
            .used(bus.id_src_used[s]),
            .wr  (wr),
            .rd  (rd),
            .sel (sel[s*SEL_W +: SEL_W]),
            .hit (hit[s])
        );
    end
    assign load_e    = wr[0] & ent[0].memread;
    // a store whose only dependence on the load is its data operand picks it up in MEM instead
    assign mem_exc   = (MEM_FWD != 0) & bus.id_memwrite & (hit == NUM_SRC'(2));
    assign bus.stall = bus.id_valid & ~bus.flush & load_e & (|hit) & ~mem_exc;
    assign take      = bus.id_valid & ~bus.stall & ~bus.flush;
    always_comb begin
        e_n   = '0;
        sel_n = '0;
        if (take) begin
            e_n   = '{valid: 1'b1, rd: RD_MAX'(bus.id_rd), regwrite: bus.id_regwrite,
                      memread: bus.id_memread, mfwd: load_e & mem_exc};
            sel_n = sel;
            if (load_e & mem_exc) sel_n[SEL_W +: SEL_W] = SEL_W'(FWD_RF);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) ent[i] <= '0;
            bus.fwd_sel   <= '0;
            bus.stall_cnt <= '0;
        end else if (!bus.freeze) begin
            ent[0] <= e_n;
            for (int i = 1; i <= DEPTH; i++) ent[i] <= ent[i-1];
            bus.fwd_sel <= sel_n;
            if (bus.stall && bus.stall_cnt != 16'hFFFF) bus.stall_cnt <= bus.stall_cnt + 16'd1;
        end
    end
    assign bus.mem_fwd = ent[1].valid & ent[1].mfwd;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: scoreboard bench for MEM_FWD=0 and MEM_FWD=1 instances against an instruction-history model
module tb_hazard_forward_ctrl;
    import hazard_forward_ctrl_pkg::*;
    localparam int REG_W = 4, NUM_SRC = 2, DEPTH = 2, SEL_W = sel_w(DEPTH);
    typedef struct packed {
        logic rst, freeze, flush, valid, rw, mr, mw;
        logic [1:0] used;
        logic [3:0] rd, s0, s1;
    } in_t;
    typedef struct packed {
        logic valid, rw, mr, mfwd;
        logic [3:0] rd;
        logic [1:0] sel0, sel1;
    } rec_t;
    typedef struct packed {
        logic stall, mem_fwd;
        logic [3:0] fwd;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    in_t cur;
    logic [1:0] stall_o, mfwd_o;
    logic [1:0][3:0] fwd_o;
    logic [1:0][15:0] cnt_o;
    always #5 clk = ~clk;
    assign rst = cur.rst;

    hazard_forward_ctrl_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus [2] ();
    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].id_valid    = cur.valid;
        assign bus[g].id_rd       = cur.rd;
        assign bus[g].id_regwrite = cur.rw;
        assign bus[g].id_memread  = cur.mr;
        assign bus[g].id_memwrite = cur.mw;
        assign bus[g].id_src      = {cur.s1, cur.s0};
        assign bus[g].id_src_used = cur.used;
        assign bus[g].flush       = cur.flush;
        assign bus[g].freeze      = cur.freeze;
        assign stall_o[g] = bus[g].stall;
        assign mfwd_o[g]  = bus[g].mem_fwd;
        assign fwd_o[g]   = bus[g].fwd_sel;
        assign cnt_o[g]   = bus[g].stall_cnt;
        hazard_forward_ctrl #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .MEM_FWD(g)) dut (
            .clk(clk), .rst(rst), .bus(bus[g]));
    end

    // h[d][k] is the instruction that entered EX k advances ago (bubble = all zero)
    rec_t h [2][DEPTH+1];
    rec_t nxt [2];
    logic stl [2];
    int cnt [2];
    exp_t q0[$], q1[$];
    int checks = 0, passes = 0, cyc = 0;

    function automatic logic writes(input rec_t r, input logic [3:0] rg);
        return r.valid && r.rw && rg != 4'd0 && r.rd == rg;
    endfunction

    task automatic cycle(input in_t i);
        logic [1:0] lh;
        logic mex, st;
        logic [1:0] sl [2];
        logic [3:0] src [2];
        exp_t e;
        cur = i;
        cyc++;
        src[0] = i.s0;
        src[1] = i.s1;
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 2; s++) begin
                lh[s] = i.used[s] && writes(h[d][0], src[s]) && h[d][0].mr;
                sl[s] = 2'd0;
                for (int k = 0; k < DEPTH && sl[s] == 2'd0; k++)
                    if (i.used[s] && writes(h[d][k], src[s])) sl[s] = 2'(k + 1);
            end
            mex = (d == 1) && i.mw && lh == 2'b10;
            st  = i.valid && !i.flush && lh != 2'b00 && !mex;
            if (mex) sl[1] = 2'd0;
            e = '{stall: st, mem_fwd: h[d][1].valid && h[d][1].mfwd,
                  fwd: {h[d][0].sel1, h[d][0].sel0}, cnt: 16'(cnt[d])};
            nxt[d] = (i.valid && !i.flush && !st) ?
                     '{valid: 1'b1, rw: i.rw, mr: i.mr, mfwd: mex, rd: i.rd, sel0: sl[0], sel1: sl[1]} : '0;
            stl[d] = st;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (i.rst) begin
                for (int k = 0; k <= DEPTH; k++) h[d][k] = '0;
                cnt[d] = 0;
            end else if (!i.freeze) begin
                for (int k = DEPTH; k > 0; k--) h[d][k] = h[d][k-1];
                h[d][0] = nxt[d];
                if (stl[d] && cnt[d] < 65535) cnt[d]++;
            end
        end
        #1;
    endtask

    task automatic chk(input int d, input string n, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL d%0d cyc%0d %s: got %0d expected %0d", d, cyc, n, got, want);
    endtask

    task automatic compare(input int d, input exp_t e);
        chk(d, "stall", int'(stall_o[d]), int'(e.stall));
        chk(d, "fwd_sel", int'(fwd_o[d]), int'(e.fwd));
        chk(d, "mem_fwd", int'(mfwd_o[d]), int'(e.mem_fwd));
        chk(d, "stall_cnt", int'(cnt_o[d]), int'(e.cnt));
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) compare(0, q0.pop_front());
        if (q1.size() > 0) compare(1, q1.pop_front());
    end

    function automatic in_t alu(input logic [3:0] rd, s0, s1);
        return '{rst: 1'b0, freeze: 1'b0, flush: 1'b0, valid: 1'b1, rw: 1'b1, mr: 1'b0, mw: 1'b0,
                 used: 2'b11, rd: rd, s0: s0, s1: s1};
    endfunction
    function automatic in_t ld(input logic [3:0] rd, base);
        in_t t = alu(rd, base, 4'd0);
        t.mr = 1'b1;
        t.used = 2'b01;
        return t;
    endfunction
    function automatic in_t sw(input logic [3:0] base, data);
        in_t t = alu(4'd0, base, data);
        t.rw = 1'b0;
        t.mw = 1'b1;
        return t;
    endfunction

    initial begin
        in_t t;
        cur = '0;
        cur.rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k <= DEPTH; k++) h[d][k] = '0;
            cnt[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        t = '0; t.rst = 1'b1; cycle(t);
        cycle('0);
        cycle(alu(3, 1, 2)); cycle(alu(5, 3, 1)); cycle('0); cycle('0);
        cycle(alu(3, 1, 1)); cycle('0); cycle(alu(6, 1, 3)); cycle('0);
        cycle(alu(3, 1, 1)); cycle(alu(3, 2, 2)); cycle(alu(7, 3, 3)); cycle('0);
        cycle(ld(4, 1)); cycle(alu(2, 4, 4)); cycle(alu(2, 4, 4)); cycle('0); cycle('0);
        cycle(ld(4, 1)); cycle(sw(7, 4)); cycle(sw(7, 4)); cycle('0); cycle('0); cycle('0);
        cycle(alu(0, 1, 1)); cycle(alu(5, 0, 0)); cycle('0);
        cycle(ld(4, 1)); t = alu(2, 4, 4); t.flush = 1'b1; cycle(t); cycle('0); cycle('0);
        cycle(ld(4, 1));
        t = alu(2, 4, 4); t.freeze = 1'b1; repeat (3) cycle(t);
        t.freeze = 1'b0; cycle(t); cycle(t); cycle('0);
        cycle(ld(4, 1)); cycle(ld(5, 4)); cycle(ld(5, 4)); cycle(alu(6, 5, 5)); cycle(alu(6, 5, 5)); cycle('0);
        cycle(alu(3, 1, 1)); cycle(ld(4, 3)); t = alu(2, 4, 3); t.rst = 1'b1; cycle(t); cycle('0); cycle('0);
        repeat (3000) begin
            t.rst    = $urandom_range(0, 59) == 0;
            t.freeze = $urandom_range(0, 9) == 0;
            t.flush  = $urandom_range(0, 9) == 0;
            t.valid  = $urandom_range(0, 4) != 0;
            t.rw     = $urandom_range(0, 3) != 0;
            t.mr     = $urandom_range(0, 2) == 0;
            t.mw     = !t.rw && $urandom_range(0, 1) == 1;
            t.used   = 2'($urandom_range(0, 3));
            t.rd     = 4'($urandom_range(0, 3));
            t.s0     = 4'($urandom_range(0, 3));
            t.s1     = 4'($urandom_range(0, 3));
            cycle(t);
        end
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() + q1.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised hazard-detection and forwarding controller for the pipelined core. Tracks in-flight destination registers for the EX stage and DEPTH trailing stages, computes per-operand forwarding selects one cycle ahead (registered at the ID→EX boundary), and raises a load-use stall. It also generates the MEM-to-MEM store-data forward and keeps a saturating stall counter. It sits beside the ID/EX pipeline register and drives the EX operand muxes, the MEM store-data mux and the IF/ID hold.

## Interface
- REG_W, 4, register address width; address 0 is hard-zero and never forwarded
- NUM_SRC, 2, source operands per instruction; index 1 is the store-data operand
- DEPTH, 2, forwarding stages after EX (1 = EX/MEM, 2 = MEM/WB, …); minimum 2
- MEM_FWD, 1, enables the MEM-to-MEM store-data path
- SEL_W, $clog2(DEPTH+1), derived width of one forwarding select
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_rd  in  REG_W  destination register
- id_regwrite  in  1  instruction writes id_rd
- id_memread  in  1  instruction is a load
- id_memwrite  in  1  instruction is a store
- id_src  in  NUM_SRC*REG_W  source registers, packed, index 0 in the LSBs
- id_src_used  in  NUM_SRC  per-source "operand actually read"
- flush  in  1  kill the decode-slot instruction (branch taken)
- freeze  in  1  global hold (memory busy); no state changes
- stall  out  1  hold PC and IF/ID; a bubble enters EX
- fwd_sel  out  NUM_SRC*SEL_W  EX operand selects: 0 = register file, k = stage k
- mem_fwd  out  1  store in MEM takes its data from the WB-stage result
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Each tracking entry holds valid, rd, regwrite, memread and mfwd. Entry E is EX; entries 1..DEPTH follow.
- "Writer" means valid & regwrite & rd≠0.
- Shift, when freeze=0: entries 1..DEPTH take entries 0..DEPTH-1.
  - E loads the ID fields when id_valid & ~stall & ~flush.
  - Otherwise E loads a bubble (valid=0).
- Next-cycle selects, per source s with id_src_used[s]:
  - Compare id_src[s] to E, which becomes stage 1, then to entries 1..DEPTH-1, which become 2..DEPTH.
  - The youngest matching writer wins, giving sel = its next stage number. No match gives 0.
  - The result is registered into fwd_sel on the same edge that loads E. A bubble loads 0.
- Load-use stall (combinational):
  - Asserted when id_valid & ~flush, E is a writer with memread, and some used source matches E.rd.
  - Exception, when MEM_FWD=1 & id_memwrite and the only matching source is index 1: no stall. mfwd=1 is loaded into E and fwd_sel for source 1 is 0.
- mem_fwd = entry 1 valid & mfwd. This is asserted when the store is in MEM and the load is in WB.
- stall_cnt increments on every edge with stall & ~freeze and saturates at 16'hFFFF.
- When freeze=1, all entries, fwd_sel and stall_cnt hold. The stall output remains combinational.
- flush overrides stall: stall=0 and a bubble enters E.
- rd=0 never matches, including for loads.

## Timing
- Reset: all entries invalid, fwd_sel=0, mem_fwd=0, stall_cnt=0. stall is 0 during reset because the entries are invalid.
- Reset mid-operation discards all in-flight tracking on the next edge.
- fwd_sel is valid for the whole cycle an instruction is in EX, with zero combinational delay from EX inputs.
- A load-use stall lasts exactly one cycle. On the following cycle the load is in stage 1 and the consumer gets sel=2.
- When stall and freeze coincide, the stall is held and not counted until freeze drops.
- Stalls from back-to-back loads are independent, one cycle each.

## Structure
- A shared package holds:
  - the entry struct (valid, rd, regwrite, memread, mfwd)
  - the FWD_RF=0 constant
  - the SEL_W derivation function
- Natural sub-module: hfc_match. It is a combinational priority comparator taking one source against the entry array and returning sel and hit flags, instantiated NUM_SRC times.

## Test plan
- ADD r3 then SUB r5,r3,r1 back-to-back: fwd_sel[0]=1 in SUB's EX cycle, stall never asserted.
- ADD r3, NOP, ADD r6,r1,r3: fwd_sel[1]=2. Two writers of r3 in stages 1 and 2: sel=1 (youngest wins).
- LW r4 then ADD r2,r4,r4: one stall cycle with a bubble in EX, then fwd_sel=2 for both sources, stall_cnt=1.
- LW r4 then SW r4,0(r7) with MEM_FWD=1: no stall, mem_fwd=1 exactly two cycles after SW leaves ID. With MEM_FWD=0: one stall.
- Writer to r0 followed by a reader of r0: fwd_sel=0. flush during a load-use stall: stall=0, bubble enters EX, count unchanged.
- freeze held for 3 cycles mid-stall: entries, fwd_sel and stall_cnt constant. rst asserted mid-stream: all outputs 0 the next cycle.
